// File: rtl/fir_pkg.sv
// Shared definitions for the symmetric FIR delay-line blocks.
// The write-pointer counter and the tap-pair reader both import this package,
// so the delay-line depth default lives here to keep the two in agreement.
package fir_pkg;

   localparam int DELAY_DEPTH = 512;

   typedef enum logic {IDLE, RUN} rdr_state_t;

   // A symmetric filter of ntaps taps needs ceil(ntaps/2) address pairs.
   // For odd lengths, the last pair is the centre tap read twice.
   function automatic int npairs(input int ntaps);
      return (ntaps + 1) / 2;
   endfunction

endpackage

// File: rtl/tap_pair_reader_if.sv
// Handshake and address bus between the tap-pair reader and its neighbours.
// slave  : the reader itself
// master : whoever issues start and consumes the address pairs
interface tap_pair_reader_if #(
   parameter int AW = $clog2(fir_pkg::DELAY_DEPTH)
);
   logic          start;
   logic [AW-1:0] wr_ptr;
   logic          busy;
   logic          rd_valid;
   logic          rd_ready;
   logic [AW-1:0] rd_addr_a;
   logic [AW-1:0] rd_addr_b;
   logic [AW-1:0] pair_idx;
   logic          center;
   logic          rd_last;
   logic          done;
   logic          overrun;
   logic          ovr_clr;

   modport slave (
      input  start, wr_ptr, rd_ready, ovr_clr,
      output busy, rd_valid, rd_addr_a, rd_addr_b, pair_idx,
             center, rd_last, done, overrun
   );

   modport master (
      output start, wr_ptr, rd_ready, ovr_clr,
      input  busy, rd_valid, rd_addr_a, rd_addr_b, pair_idx,
             center, rd_last, done, overrun
   );
endinterface

// File: rtl/tap_pair_reader_circ_addr_sub.sv
// Circular-buffer address helper: (base - off) mod 2^AW.
// Purely combinational; plain unsigned subtraction wraps for free because the
// delay line depth is a power of two.
module circ_addr_sub #(
   parameter int AW = 9
) (
   input  logic [AW-1:0] base,
   input  logic [AW-1:0] off,
   output logic [AW-1:0] diff
);

   assign diff = base - off;

endmodule

// File: rtl/tap_pair_reader.sv
// Read-side address sequencer for the symmetric FIR circular delay line.
// Each pass walks k = 0..NPAIRS-1 and presents the pair
//    addr_a = base - k,  addr_b = base - (NTAPS-1-k)   (mod DEPTH)
// to the pre-adder/MAC path with a valid/ready handshake.
// Optional feature: define READER_OVERRUN_EN to enable the sticky overrun flag
// (start seen while busy). Without it, overrun is tied low and ovr_clr is unused.
module tap_pair_reader
   import fir_pkg::*;
#(
   parameter  int DEPTH = DELAY_DEPTH,
   parameter  int NTAPS = 64,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   tap_pair_reader_if.slave   bus
);

   localparam logic [AW-1:0] LAST_K = AW'(npairs(NTAPS) - 1);
   localparam logic [AW-1:0] SPAN   = AW'(NTAPS - 1);
   localparam bit            ODD    = (NTAPS % 2) == 1;

   rdr_state_t    state;
   logic [AW-1:0] base;

   logic          handshake;
   logic          last_hs;
   logic          accept_start;
   logic          load_pair;
   logic [AW-1:0] nxt_base;
   logic [AW-1:0] nxt_k;
   logic [AW-1:0] nxt_off_b;
   logic [AW-1:0] nxt_addr_a;
   logic [AW-1:0] nxt_addr_b;

   // Decide what the next presented pair will be: a fresh pass on an accepted
   // start (including the back-to-back case), the next k on a non-final
   // handshake, otherwise hold.
   always_comb begin
      handshake    = bus.rd_valid && bus.rd_ready;
      last_hs      = handshake && bus.rd_last;
      accept_start = bus.start && ((state == IDLE) || last_hs);
      load_pair    = accept_start || (handshake && !bus.rd_last);
      nxt_base     = base;
      nxt_k        = bus.pair_idx;
      if (accept_start) begin
         nxt_base = bus.wr_ptr;
         nxt_k    = '0;
      end else if (handshake && !bus.rd_last) begin
         nxt_k = bus.pair_idx + 1'b1;
      end
      nxt_off_b = SPAN - nxt_k;
   end

   circ_addr_sub #(.AW(AW)) u_sub_a (
      .base (nxt_base),
      .off  (nxt_k),
      .diff (nxt_addr_a)
   );

   circ_addr_sub #(.AW(AW)) u_sub_b (
      .base (nxt_base),
      .off  (nxt_off_b),
      .diff (nxt_addr_b)
   );

   // Pass sequencing FSM; every output is registered so the consumer sees a
   // stable pair for as long as it stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         base          <= '0;
         bus.busy      <= 1'b0;
         bus.rd_valid  <= 1'b0;
         bus.rd_addr_a <= '0;
         bus.rd_addr_b <= '0;
         bus.pair_idx  <= '0;
         bus.center    <= 1'b0;
         bus.rd_last   <= 1'b0;
         bus.done      <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (accept_start) begin
                  state        <= RUN;
                  bus.busy     <= 1'b1;
                  bus.rd_valid <= 1'b1;
               end
            end
            RUN: begin
               if (last_hs) begin
                  bus.done <= 1'b1;
                  if (!accept_start) begin
                     state        <= IDLE;
                     bus.busy     <= 1'b0;
                     bus.rd_valid <= 1'b0;
                  end
               end
            end
         endcase
         if (load_pair) begin
            base          <= nxt_base;
            bus.pair_idx  <= nxt_k;
            bus.rd_addr_a <= nxt_addr_a;
            bus.rd_addr_b <= nxt_addr_b;
            bus.rd_last   <= (nxt_k == LAST_K);
            bus.center    <= ODD && (nxt_k == LAST_K);
         end else if (last_hs) begin
            bus.pair_idx  <= '0;
            bus.rd_addr_a <= '0;
            bus.rd_addr_b <= '0;
            bus.rd_last   <= 1'b0;
            bus.center    <= 1'b0;
         end
      end
   end

`ifdef READER_OVERRUN_EN
   logic ignored_start;

   // A start that lands mid-pass (not on the final handshake) is dropped.
   always_comb begin
      ignored_start = bus.start && (state == RUN) && !last_hs;
   end

   // Sticky overrun flag; a new ignored start beats a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.overrun <= 1'b0;
      end else if (ignored_start) begin
         bus.overrun <= 1'b1;
      end else if (bus.ovr_clr) begin
         bus.overrun <= 1'b0;
      end
   end
`else
   assign bus.overrun = 1'b0;
`endif

endmodule
